dsc_sng3: RTL and testbench
===========================

# dsc_sng3

Deterministic stochastic-number generator for the 3-input sorting path. It accepts one sorted triple (max, mid, min) from the 3-input compare-and-swap stage through a valid/ready handshake and latches it. It then emits three unary bitstreams of length 2^SNG_WIDTH, driven by a shared up-counter. The bitstreams feed the downstream DSC arithmetic units (multipliers, adders).

## Interface
- SNG_WIDTH, 8, binary value width; stream length is 2^SNG_WIDTH cycles.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  triple on in_max/in_mid/in_min is valid.
- in_ready  output  1  block is idle and can accept a triple.
- in_max  input  SNG_WIDTH  largest value (sorter output a_new).
- in_mid  input  SNG_WIDTH  middle value (sorter output b_new).
- in_min  input  SNG_WIDTH  smallest value (sorter output c_new).
- s_max  output  1  unary stream for latched max.
- s_mid  output  1  unary stream for latched mid.
- s_min  output  1  unary stream for latched min.
- stream_valid  output  1  s_* carry stream bits this cycle.
- done  output  1  one-cycle pulse on the final stream bit.
- order_err  output  1  latched triple violated max >= mid >= min.

## Operation
- Two states: IDLE and RUN.
- IDLE:
  - in_ready = 1; stream_valid = 0; done = 0; s_* = 0.
  - On in_valid && in_ready at a clock edge: latch the three values into val_max/val_mid/val_min; clear cnt to 0; go to RUN.
- On the same acceptance edge, order_err is registered as !(in_max >= in_mid && in_mid >= in_min), using unsigned compare. order_err holds until the next acceptance or reset. It is informational only: generation proceeds regardless.
- RUN:
  - in_ready = 0; stream_valid = 1.
  - s_x = (cnt < val_x), unsigned, full SNG_WIDTH compare.
  - cnt increments by 1 each cycle.
  - in_valid is ignored, with no latching and no error.
- At cnt == 2^SNG_WIDTH - 1: done = 1 for that cycle (the final bit). The next edge returns to IDLE, with cnt wrapping to 0.
- The number of ones emitted per stream over one run equals val_x exactly.
  - Value 0 gives all zeros.
  - Value 2^SNG_WIDTH - 1 gives ones everywhere except the final bit.
- For a correctly sorted input, s_min implies s_mid implies s_max on every cycle, so the streams are maximally correlated.
- Reset (synchronous, any state including mid-RUN):
  - State = IDLE; cnt = 0; val_* = 0; order_err = 0.
  - Outputs become in_ready = 1, stream_valid = 0, done = 0, s_* = 0 from the first cycle after the reset edge.
  - A partial stream is discarded; no done pulse is emitted.
- rst takes priority over a simultaneous in_valid.

## Timing
- Accept edge at cycle T. First stream bit (cnt = 0) is valid during cycle T+1.
- Last bit (cnt = 2^SNG_WIDTH - 1) is valid during cycle T+2^SNG_WIDTH, with done = 1 in that cycle.
- in_ready rises in cycle T+2^SNG_WIDTH+1. The earliest next acceptance is at the end of that cycle.
- Throughput: one triple per 2^SNG_WIDTH + 1 cycles (257 at default).
- in_ready depends only on state (no combinational path from in_valid).
- s_* are combinational from registered cnt and val_* only. stream_valid, done, in_ready and order_err decode from registers.
- Sorter upstream is combinational, so in_* must be stable only at the acceptance edge.

## Test plan
- Accept (200, 100, 0):
  - stream_valid high exactly 256 cycles.
  - Ones counted: s_max 200, s_mid 100, s_min 0.
  - done exactly once, on the 256th stream cycle.
  - order_err = 0.
- Accept (255, 255, 1):
  - s_max and s_mid are 1 for cnt 0..254 and 0 at cnt 255.
  - s_min is 1 only at cnt 0.
  - s_min implies s_mid implies s_max is checked every cycle.
- Accept (5, 9, 1):
  - order_err = 1 from the cycle after acceptance.
  - Ones counts are 5, 9, 1.
  - A following accept of (9, 5, 1) clears order_err.
- Hold in_valid = 1 with changing data throughout RUN:
  - No relatch; counts match the first triple.
  - The second triple is accepted at the first edge where in_ready = 1, 257 cycles after the first accept.
- Assert rst at cnt = 100 during a run of (128, 64, 32):
  - Next cycle shows in_ready = 1, stream_valid = 0, s_* = 0, order_err = 0, and no done pulse.
  - A fresh accept of (10, 10, 10) yields 10 ones per stream.
- rst and in_valid high on the same edge: the triple is not accepted; the block remains in IDLE.

Source files
------------

// File: rtl/dsc_sng3.sv
// Deterministic stochastic-number generator for a sorted triple (max, mid, min).
// Latches one triple, then emits three unary bitstreams of 2^SNG_WIDTH bits from a shared up-counter.
module dsc_sng3 #(
   parameter int SNG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SNG_WIDTH-1:0] in_max,
   input  logic [SNG_WIDTH-1:0] in_mid,
   input  logic [SNG_WIDTH-1:0] in_min,
   output logic                 s_max,
   output logic                 s_mid,
   output logic                 s_min,
   output logic                 stream_valid,
   output logic                 done,
   output logic                 order_err
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [SNG_WIDTH-1:0] CNT_LAST = {SNG_WIDTH{1'b1}};

   state_t               state;
   state_t               state_nxt;
   logic [SNG_WIDTH-1:0] cnt;
   logic [SNG_WIDTH-1:0] val_max;
   logic [SNG_WIDTH-1:0] val_mid;
   logic [SNG_WIDTH-1:0] val_min;
   logic                 accept;
   logic                 last_bit;
   logic                 in_sorted;

   // in_ready is a pure state decode, so accept has no path from in_valid to in_ready.
   assign accept    = in_valid && in_ready;
   assign last_bit  = (cnt == CNT_LAST);
   assign in_sorted = (in_max >= in_mid) && (in_mid >= in_min);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_nxt
      // unassigned and infers a latch.
      state_nxt = state;
      unique case (state)
         IDLE: if (accept)   state_nxt = RUN;
         RUN:  if (last_bit) state_nxt = IDLE;
         default:            state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         val_max   <= '0;
         val_mid   <= '0;
         val_min   <= '0;
         order_err <= 1'b0;
      end else if (accept) begin
         cnt       <= '0;
         val_max   <= in_max;
         val_mid   <= in_mid;
         val_min   <= in_min;
         order_err <= !in_sorted;
      end else if (state == RUN) begin
         // Wraps to zero on the final bit, leaving cnt clean for the next run.
         cnt <= cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      in_ready     = 1'b0;
      stream_valid = 1'b0;
      done         = 1'b0;
      s_max        = 1'b0;
      s_mid        = 1'b0;
      s_min        = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
         end
         RUN: begin
            stream_valid = 1'b1;
            done         = last_bit;
            s_max        = (cnt < val_max);
            s_mid        = (cnt < val_mid);
            s_min        = (cnt < val_min);
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dsc_sng3.sv
// Self-checking bench for dsc_sng3: stimulus pushes expected run summaries into a
// scoreboard queue; a negedge monitor checks each observed stream against them.
module tb_dsc_sng3;

   localparam int W   = 8;
   localparam int LEN = 1 << W;

   typedef struct {
      int vmax;
      int vmid;
      int vmin;
      bit err;
      int len;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_max = '0;
   logic [W-1:0] in_mid = '0;
   logic [W-1:0] in_min = '0;
   logic         in_ready;
   logic         s_max;
   logic         s_mid;
   logic         s_min;
   logic         stream_valid;
   logic         done;
   logic         order_err;

   int   vectors    = 0;
   int   miscompares = 0;
   exp_t exp_q[$];
   exp_t cur;
   bit   armed  = 1'b0;
   bit   active = 1'b0;
   int   run_len;
   int   ones[3];
   bit   seen_zero[3];
   int   dones;

   dsc_sng3 #(.SNG_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_max       (in_max),
      .in_mid       (in_mid),
      .in_min       (in_min),
      .s_max        (s_max),
      .s_mid        (s_mid),
      .s_min        (s_min),
      .stream_valid (stream_valid),
      .done         (done),
      .order_err    (order_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic exp_t mk(input int a, input int b, input int c, input int len);
      exp_t e;
      e.vmax = a;
      e.vmid = b;
      e.vmin = c;
      e.err  = !(a >= b && b >= c);
      e.len  = len;
      return e;
   endfunction

   // Monitor: an observed stream is a maximal run of stream_valid cycles.
   always @(negedge clk) begin
      if (armed) begin
         if (stream_valid) begin
            if (!active) begin
               check("pending_run", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  cur     = exp_q.pop_front();
                  active  = 1'b1;
                  run_len = 0;
                  dones   = 0;
                  for (int i = 0; i < 3; i++) begin
                     ones[i]      = 0;
                     seen_zero[i] = 1'b0;
                  end
               end
            end
            if (active) begin
               logic [2:0] bits;
               bits = {s_max, s_mid, s_min};
               run_len++;
               for (int i = 0; i < 3; i++) begin
                  if (bits[i]) begin
                     ones[i]++;
                     check("unary_prefix", seen_zero[i], 0);
                  end else begin
                     seen_zero[i] = 1'b1;
                  end
               end
               check("order_err", order_err, cur.err);
               check("in_ready_in_run", in_ready, 0);
               if (!cur.err) check("correlation", (s_min <= s_mid) && (s_mid <= s_max), 1);
               if (done) begin
                  dones++;
                  check("done_position", run_len, LEN);
               end
            end
         end else begin
            check("idle_outputs", {s_max, s_mid, s_min, done}, 0);
            if (active) begin
               active = 1'b0;
               check("stream_length", run_len, cur.len);
               check("ones_max", ones[2], min2(cur.vmax, cur.len));
               check("ones_mid", ones[1], min2(cur.vmid, cur.len));
               check("ones_min", ones[0], min2(cur.vmin, cur.len));
               check("done_count", dones, (cur.len == LEN) ? 1 : 0);
            end
         end
      end
   end

   // Present a triple from a negedge and hold it until an accepting edge.
   task automatic send(input int a, input int b, input int c, input int len, input bit keep);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_max   = a[W-1:0];
      in_mid   = b[W-1:0];
      in_min   = c[W-1:0];
      while (!in_ready && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      check("accept_in_time", waited < 1000, 1);
      if (waited < 1000) begin
         @(posedge clk);
         exp_q.push_back(mk(a, b, c, len));
         #1;
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      while ((active || exp_q.size() != 0 || !in_ready) && w < 1000) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      check("idle_in_time", w < 1000, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;
      int t[3];

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_in_ready", in_ready, 1);
      check("reset_stream_valid", stream_valid, 0);
      check("reset_order_err", order_err, 0);
      check("reset_done", done, 0);
      armed = 1'b1;

      send(200, 100, 0, LEN, 0);
      send(255, 255, 1, LEN, 0);
      send(5, 9, 1, LEN, 0);
      send(9, 5, 1, LEN, 0);

      // Keep in_valid high with changing data for the whole run.
      send(77, 33, 12, LEN, 1);
      edges = 0;
      while (edges < 600) begin
         @(negedge clk);
         if (in_ready) begin
            in_max = 8'd255;
            in_mid = 8'd128;
            in_min = 8'd3;
            @(posedge clk);
            edges++;
            exp_q.push_back(mk(255, 128, 3, LEN));
            break;
         end
         in_max = W'($urandom_range(0, 255));
         in_mid = W'($urandom_range(0, 255));
         in_min = W'($urandom_range(0, 255));
         @(posedge clk);
         edges++;
      end
      #1 in_valid = 1'b0;
      check("reaccept_gap", edges, LEN + 1);

      // Reset while cnt == 100: streams for cnt 0..100 are observed, then aborted.
      send(128, 64, 32, 101, 0);
      repeat (100) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_stream_valid", stream_valid, 0);
      check("abort_streams", {s_max, s_mid, s_min}, 0);
      check("abort_order_err", order_err, 0);
      check("abort_done", done, 0);
      send(10, 10, 10, LEN, 0);
      wait_idle();

      // Reset wins over a simultaneous in_valid.
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_max   = 8'd50;
      in_mid   = 8'd40;
      in_min   = 8'd30;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_prio_in_ready", in_ready, 1);
      check("rst_prio_stream_valid", stream_valid, 0);
      repeat (3) @(negedge clk);
      check("rst_prio_still_idle", stream_valid, 0);

      // Random triples, mostly sorted.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 3; i++) t[i] = $urandom_range(0, LEN - 1);
         if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 2; i++) begin
               for (int j = 0; j < 2 - i; j++) begin
                  if (t[j] < t[j+1]) begin
                     int tmp;
                     tmp    = t[j];
                     t[j]   = t[j+1];
                     t[j+1] = tmp;
                  end
               end
            end
         end
         send(t[0], t[1], t[2], LEN, 0);
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
